// File: rtl/fp_add_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_seq_if
//  Description : Operand/result handshake bundle for the sequential
//                single-precision adder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_add_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, ovf
  );
endinterface
`default_nettype wire

// File: rtl/fp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_seq
//  Description : Multi-cycle IEEE-754 single-precision adder. One operation
//                in flight; 1-bit-per-cycle alignment and normalization,
//                round-to-nearest-even on guard/round/sticky.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_seq (
  input  wire logic   clk,
  input  wire logic   rst_n,
  fp_add_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

  state_t      r_state, w_state_nxt;
  logic        r_sx, w_sx_nxt;          // sign of larger-magnitude operand
  logic        r_sub, w_sub_nxt;        // operand signs differ
  logic        r_zsign, w_zsign_nxt;    // sign used for an exact-zero sum
  logic [8:0]  r_ex, w_ex_nxt;          // working exponent (room for 256)
  logic [23:0] r_mx, w_mx_nxt;          // larger mantissa
  logic [26:0] r_my, w_my_nxt;          // smaller mantissa + G/R/S
  logic [7:0]  r_diff, w_diff_nxt;      // remaining alignment distance
  logic [27:0] r_sum, w_sum_nxt;        // carry + 24-bit mantissa + G/R/S
  logic [31:0] r_result, w_result_nxt;
  logic        r_ovf, w_ovf_nxt;

  // Operand decode, only meaningful while capturing in IDLE
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_special, w_a_ge_b;
  logic [31:0] w_spec_res;

  // Decode both operands and resolve NaN/Inf results up front
  always_comb begin
    w_ea     = (bus.a[30:23] == 8'd0) ? 8'd1 : bus.a[30:23];
    w_eb     = (bus.b[30:23] == 8'd0) ? 8'd1 : bus.b[30:23];
    w_ma     = {(bus.a[30:23] != 8'd0), bus.a[22:0]};
    w_mb     = {(bus.b[30:23] != 8'd0), bus.b[22:0]};
    w_a_nan  = (&bus.a[30:23]) && (|bus.a[22:0]);
    w_b_nan  = (&bus.b[30:23]) && (|bus.b[22:0]);
    w_a_inf  = (&bus.a[30:23]) && !(|bus.a[22:0]);
    w_b_inf  = (&bus.b[30:23]) && !(|bus.b[22:0]);
    w_special = (&bus.a[30:23]) || (&bus.b[30:23]);
    w_a_ge_b = ({w_ea, w_ma} >= {w_eb, w_mb});
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (bus.a[31] != bus.b[31])))
      w_spec_res = C_QNAN;
    else if (w_a_inf)
      w_spec_res = bus.a;
    else
      w_spec_res = bus.b;
  end

  // Datapath arithmetic for ADD and ROUND
  logic [27:0] w_xext, w_yext, w_add;
  logic [23:0] w_rmant, w_fmant;
  logic        w_rup;
  logic [24:0] w_rsum;
  logic [8:0]  w_rexp;

  // Add/subtract aligned mantissas and apply round-to-nearest-even
  always_comb begin
    w_xext  = {1'b0, r_mx, 3'b000};
    w_yext  = {1'b0, r_my};
    w_add   = r_sub ? (w_xext - w_yext) : (w_xext + w_yext);
    w_rmant = r_sum[26:3];
    w_rup   = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
    w_rsum  = {1'b0, w_rmant} + {24'd0, w_rup};
    if (w_rsum[24]) begin
      w_fmant = w_rsum[24:1];
      w_rexp  = r_ex + 9'd1;
    end else begin
      w_fmant = w_rsum[23:0];
      w_rexp  = r_ex;
    end
  end

  // Next-state and next-datapath logic for the sequencing FSM
  always_comb begin
    w_state_nxt  = r_state;
    w_sx_nxt     = r_sx;
    w_sub_nxt    = r_sub;
    w_zsign_nxt  = r_zsign;
    w_ex_nxt     = r_ex;
    w_mx_nxt     = r_mx;
    w_my_nxt     = r_my;
    w_diff_nxt   = r_diff;
    w_sum_nxt    = r_sum;
    w_result_nxt = r_result;
    w_ovf_nxt    = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (w_special) begin
            w_result_nxt = w_spec_res;
            w_ovf_nxt    = 1'b0;
            w_state_nxt  = S_DONE;
          end else begin
            w_sub_nxt   = bus.a[31] ^ bus.b[31];
            w_zsign_nxt = bus.a[31] & bus.b[31];
            if (w_a_ge_b) begin
              w_sx_nxt   = bus.a[31];
              w_ex_nxt   = {1'b0, w_ea};
              w_mx_nxt   = w_ma;
              w_my_nxt   = {w_mb, 3'b000};
              w_diff_nxt = w_ea - w_eb;
            end else begin
              w_sx_nxt   = bus.b[31];
              w_ex_nxt   = {1'b0, w_eb};
              w_mx_nxt   = w_mb;
              w_my_nxt   = {w_ma, 3'b000};
              w_diff_nxt = w_eb - w_ea;
            end
            w_state_nxt = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        if (r_diff == 8'd0) begin
          w_state_nxt = S_ADD;
        end else if (r_diff >= 8'd27) begin
          // Everything lands below the round bit: only stickiness survives
          w_my_nxt    = {26'd0, |r_my};
          w_diff_nxt  = 8'd0;
          w_state_nxt = S_ADD;
        end else begin
          w_my_nxt   = {1'b0, r_my[26:2], r_my[1] | r_my[0]};
          w_diff_nxt = r_diff - 8'd1;
        end
      end
      S_ADD: begin
        w_sum_nxt = w_add;
        if (w_add == 28'd0) begin
          w_result_nxt = {r_zsign, 31'd0};
          w_ovf_nxt    = 1'b0;
          w_state_nxt  = S_DONE;
        end else begin
          w_state_nxt = S_NORM;
        end
      end
      S_NORM: begin
        if (r_sum[27]) begin
          w_sum_nxt   = {1'b0, r_sum[27:2], r_sum[1] | r_sum[0]};
          w_ex_nxt    = r_ex + 9'd1;
          w_state_nxt = S_ROUND;
        end else if (!r_sum[26] && (r_ex > 9'd1)) begin
          w_sum_nxt = {r_sum[26:0], 1'b0};
          w_ex_nxt  = r_ex - 9'd1;
        end else begin
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        if (w_rexp >= 9'd255) begin
          w_result_nxt = {r_sx, 8'hFF, 23'd0};
          w_ovf_nxt    = 1'b1;
        end else begin
          // A mantissa without its leading one can only occur at exponent 1
          w_result_nxt = {r_sx, (w_fmant[23] ? w_rexp[7:0] : 8'd0), w_fmant[22:0]};
          w_ovf_nxt    = 1'b0;
        end
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sx     <= 1'b0;
      r_sub    <= 1'b0;
      r_zsign  <= 1'b0;
      r_ex     <= 9'd0;
      r_mx     <= 24'd0;
      r_my     <= 27'd0;
      r_diff   <= 8'd0;
      r_sum    <= 28'd0;
      r_result <= 32'd0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sx     <= w_sx_nxt;
      r_sub    <= w_sub_nxt;
      r_zsign  <= w_zsign_nxt;
      r_ex     <= w_ex_nxt;
      r_mx     <= w_mx_nxt;
      r_my     <= w_my_nxt;
      r_diff   <= w_diff_nxt;
      r_sum    <= w_sum_nxt;
      r_result <= w_result_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_seq
//  Description : Self-checking bench for fp_add_seq: directed corner cases
//                plus random operands against an exact-integer IEEE model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_seq;

  logic clk = 1'b0;
  logic rst_n;

  fp_add_seq_if bus ();

  fp_add_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] r_res;
  logic        r_ovf;
  int          lat;
  logic        ready_bad;
  logic        tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Exact sum of two binary32 values as integers scaled by 2^149, then
  // rounded to nearest-even.  Returns {ovf, result}.
  function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic signed [299:0] ma, mb, s, mag;
    logic        [299:0] rem, half, one;
    logic        [24:0]  m;
    logic                sign, up;
    int                  p, sh, e;
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[31] != b[31])) return {1'b0, 32'h7FC00000};
    if (a_inf) return {1'b0, a};
    if (b_inf) return {1'b0, b};
    ma = (a[30:23] == 0) ? 300'(a[22:0]) : 300'({1'b1, a[22:0]});
    mb = (b[30:23] == 0) ? 300'(b[22:0]) : 300'({1'b1, b[22:0]});
    if (a[30:23] > 1) ma = ma << (int'(a[30:23]) - 1);
    if (b[30:23] > 1) mb = mb << (int'(b[30:23]) - 1);
    s = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
    if (s == 0) return {1'b0, a[31] & b[31], 31'd0};
    sign = (s < 0);
    mag  = sign ? -s : s;
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p <= 23) return {1'b0, sign, mag[30:0]};
    sh   = p - 23;
    m    = 25'(mag >> sh);
    one  = 300'd1;
    rem  = mag & ((one << sh) - one);
    half = one << (sh - 1);
    up   = (rem > half) || ((rem == half) && m[0]);
    m    = m + 25'(up);
    if (m[24]) begin
      m  = m >> 1;
      sh = sh + 1;
    end
    e = sh + 1;
    if (e >= 255) return {1'b1, sign, 8'hFF, 23'd0};
    return {1'b0, sign, 8'(e), m[22:0]};
  endfunction

  // Present an operand pair; returns at the falling edge after capture
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!bus.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
  endtask

  // Latency counts the capture cycle as cycle 1
  task automatic wait_done();
    lat       = 2;
    ready_bad = 1'b0;
    while (!bus.out_valid && lat < 80) begin
      if (bus.in_ready) ready_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (bus.in_ready) ready_bad = 1'b1;
    tmo   = !bus.out_valid;
    r_res = bus.result;
    r_ovf = bus.ovf;
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_ovf);
    logic special;
    special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    start_op(a, b);
    wait_done();
    chk({tag, "_timeout"}, 32'(tmo), 32'd0);
    chk({tag, "_res"}, r_res, exp_res);
    chk({tag, "_ovf"}, 32'(r_ovf), 32'(exp_ovf));
    chk({tag, "_busy_ready"}, 32'(ready_bad), 32'd0);
    if (special) begin
      chk({tag, "_lat"}, 32'(lat), 32'd2);
    end else begin
      n_vec++;
      assert (lat <= 55) else begin
        n_miss++;
        $error("FAIL %s_lat observed=%0d expected=<=55", tag, lat);
      end
    end
    accept();
  endtask

  initial begin
    logic [31:0] a, b, h_res;
    logic [32:0] ex;
    logic        h_ovf, stable, seen;
    int          cls, e;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    bus.result,         32'd0);
    chk("rst_ovf",       32'(bus.ovf),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("one_plus_two", 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);
    do_op("cancel",       32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0);
    do_op("negzero",      32'h80000000, 32'h80000000, 32'h80000000, 1'b0);
    do_op("tie_even",     32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0);
    do_op("tie_odd",      32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0);
    do_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
    do_op("inf_minf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0);
    do_op("nan_in",       32'h7F800123, 32'h3F800000, 32'h7FC00000, 1'b0);
    do_op("minf_fin",     32'hFF800000, 32'h42000000, 32'hFF800000, 1'b0);
    do_op("denorm_sum",   32'h00400000, 32'h00400000, 32'h00800000, 1'b0);
    do_op("denorm_diff",  32'h00800001, 32'h80800000, 32'h00000001, 1'b0);

    // Result must hold while the consumer stalls
    start_op(32'h3F800000, 32'h40000000);
    wait_done();
    chk("hold_res", r_res, 32'h40400000);
    h_res  = bus.result;
    h_ovf  = bus.ovf;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.result !== h_res || bus.ovf !== h_ovf || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("hold_stable", 32'(stable), 32'd1);
    accept();
    chk("release_in_ready",  32'(bus.in_ready),  32'd1);
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of alignment
    start_op(32'h3F800000, 32'h00000001);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result",    bus.result,         32'd0);
    chk("midrst_ovf",       32'(bus.ovf),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    do_op("after_rst", 32'h40000000, 32'h40000000, 32'h40800000, 1'b0);

    // Random operands biased toward cancellation, denormals and overflow
    for (int k = 0; k < 250; k++) begin
      a   = $urandom;
      b   = $urandom;
      cls = $urandom_range(0, 4);
      case (cls)
        1: begin
          b[31]    = ~a[31];
          b[30:23] = a[30:23] ^ 8'($urandom_range(0, 1));
          b[22:0]  = a[22:0] ^ 23'($urandom_range(0, 15));
        end
        2: begin
          a[30:23] = 8'd0;
          b[30:23] = 8'($urandom_range(0, 1));
        end
        3: begin
          a[30:23] = 8'hFE;
          b[30:23] = 8'($urandom_range(240, 254));
        end
        4: begin
          e = int'(a[30:23]) - int'($urandom_range(20, 30));
          if (e < 0) e = 0;
          b[30:23] = 8'(e);
        end
        default: ;
      endcase
      ex = ref_add(a, b);
      do_op($sformatf("rnd%0d", k), a, b, ex[31:0], ex[32]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
